// File: rtl/j1_uart_pkg.sv
// Shared definitions for the J1 UART peripheral: register offsets,
// STATUS bit positions and the state encoding used by both serial FSMs.
package j1_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_RX_VALID   = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_TX_DROP    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/j1_uart_rx.sv
// UART receiver: synchronises the asynchronous serial input, detects a
// start bit, samples eight data bits LSB first near their centres and
// checks the stop bit. Produces a byte with a one-cycle strobe.
module j1_uart_rx
  import j1_uart_pkg::*;
(
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        uart_rx_i,
  input  logic [15:0] divisor,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  output logic        rx_frame_err
);

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic        rx_fall;
  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Receive FSM: half-bit wait to the start-bit centre, then one sample per bit period.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state        <= ST_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_byte      <= '0;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state    <= ST_START;
            baud_cnt <= divisor >> 1;
          end
        end
        ST_START: begin
          if (baud_cnt == 16'd0) begin
            if (rx_sync) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              baud_cnt <= divisor;
              bit_cnt  <= 3'd0;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == 16'd0) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            baud_cnt  <= divisor;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == 16'd0) begin
            state        <= ST_IDLE;
            rx_byte      <= shift_reg;
            rx_strobe    <= 1'b1;
            rx_frame_err <= ~rx_sync;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/j1_io_uart.sv
// Memory-mapped UART for the J1 IO bus. Decodes an 8-byte window,
// holds the TX/RX/STATUS/DIVISOR registers, runs the transmit FSM and
// hosts the receiver. Read data is combinational and zero when not selected.
module j1_io_uart
  import j1_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd_i,
  input  logic        io_wr_i,
  input  logic [15:0] io_addr_i,
  input  logic [15:0] io_wdata_i,
  output logic [15:0] io_rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);

  logic        hit;
  logic [1:0]  offset;
  logic        wr_tx;
  logic        wr_status;
  logic        wr_div;
  logic        rd_rx;
  logic        unused_addr_lsb;

  logic [15:0] divisor;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;
  logic        tx_drop;
  logic        tx_busy;
  logic [15:0] status_word;

  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit_cnt;
  logic [7:0]  tx_shift;
  logic        tx_line;

  logic [7:0]  rx_new_byte;
  logic        rx_strobe;
  logic        rx_frame_err;

  assign hit             = (io_addr_i[15:3] == BASE_ADDR[15:3]);
  assign offset          = io_addr_i[2:1];
  assign unused_addr_lsb = io_addr_i[0];

  assign wr_tx     = io_wr_i & hit & (offset == REG_TXDATA);
  assign wr_status = io_wr_i & hit & (offset == REG_STATUS);
  assign wr_div    = io_wr_i & hit & (offset == REG_DIVISOR);
  assign rd_rx     = io_rd_i & hit & (offset == REG_RXDATA);

  assign tx_busy   = (tx_state != ST_IDLE);
  assign uart_tx_o = tx_line;

  assign status_word = {11'd0, tx_drop, frame_err, rx_overrun, rx_valid, tx_busy};

  j1_uart_rx u_rx (
    .sys_clk_i    (sys_clk_i),
    .sys_rst_i    (sys_rst_i),
    .uart_rx_i    (uart_rx_i),
    .divisor      (divisor),
    .rx_byte      (rx_new_byte),
    .rx_strobe    (rx_strobe),
    .rx_frame_err (rx_frame_err)
  );

  // Combinational read mux; drives zero unless this window is being read.
  always_comb begin
    io_rdata_o = 16'd0;
    if (io_rd_i && hit) begin
      case (offset)
        REG_RXDATA:  io_rdata_o = {8'h00, rx_byte};
        REG_STATUS:  io_rdata_o = status_word;
        REG_DIVISOR: io_rdata_o = divisor;
        default:     io_rdata_o = 16'd0;
      endcase
    end
  end

  // Register file and sticky status flags; a set on the same edge as a clear wins.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      divisor    <= DEFAULT_DIV;
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      if (wr_div) begin
        divisor <= io_wdata_i;
      end
      if (rx_strobe) begin
        rx_byte <= rx_new_byte;
      end
      if (rx_strobe) begin
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_strobe && rx_valid && !rd_rx) begin
        rx_overrun <= 1'b1;
      end else if (wr_status && io_wdata_i[STAT_RX_OVERRUN]) begin
        rx_overrun <= 1'b0;
      end
      if (rx_strobe && rx_frame_err) begin
        frame_err <= 1'b1;
      end else if (wr_status && io_wdata_i[STAT_FRAME_ERR]) begin
        frame_err <= 1'b0;
      end
      if (wr_tx && tx_busy) begin
        tx_drop <= 1'b1;
      end else if (wr_status && io_wdata_i[STAT_TX_DROP]) begin
        tx_drop <= 1'b0;
      end
    end
  end

  // Transmit FSM: start, eight data bits LSB first, stop; each held divisor+1 clocks.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state   <= ST_IDLE;
      tx_cnt     <= 16'd0;
      tx_bit_cnt <= 3'd0;
      tx_shift   <= 8'd0;
      tx_line    <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx_line <= 1'b1;
          if (wr_tx) begin
            tx_state <= ST_START;
            tx_line  <= 1'b0;
            tx_cnt   <= divisor;
            tx_shift <= io_wdata_i[7:0];
          end
        end
        ST_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state   <= ST_DATA;
            tx_line    <= tx_shift[0];
            tx_cnt     <= divisor;
            tx_bit_cnt <= 3'd0;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= divisor;
            if (tx_bit_cnt == 3'd7) begin
              tx_state <= ST_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 3'd1;
              tx_shift   <= tx_shift >> 1;
              tx_line    <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

endmodule
